fb_paint_writer: RTL and testbench

Framebuffer-side sink for the cursor/paint pixel stream in the paint subsystem. It accepts `paint` strobes carrying `px_data` and 8-bit coordinates, clips them to the 64x64 canvas, and buffers them in a 4-entry FIFO. It writes each pixel into the shared framebuffer RAM through a request/grant port, where the display scanner has priority. With XOR mode compiled in, each write is a read-modify-write, so a cursor painted twice erases itself.

---
 rtl/fb_paint_writer.sv | 161 ++++++++++++++++
 tb/tb_fb_paint_writer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_paint_writer.sv
// fb_paint_writer: clips paint strobes to the canvas, queues them and writes each pixel into the framebuffer RAM.
// Latency: paint at edge N -> mem_req after N+1 -> commit at N+2 (XOR build: commit at N+4); each ungranted cycle adds one.
// Backpressure: ready = !full; strobes seen while full or off-canvas are dropped and counted in drop_cnt.
// Build option: define FB_PAINT_XOR_EN to make every write a read-modify-write XOR of the old pixel.
module fb_paint_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FB_DIM_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     paint,
    input  logic [7:0]               px_data,
    input  logic [7:0]               in_x,
    input  logic [7:0]               in_y,
    output logic                     ready,
    output logic                     idle,
    output logic [7:0]               drop_cnt,
    output logic                     mem_req,
    input  logic                     mem_grant,
    output logic                     mem_we,
    output logic [2*FB_DIM_LOG2-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata
);
    localparam int AW  = 2 * FB_DIM_LOG2;
    localparam int EW  = AW + 8;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int DIM = 1 << FB_DIM_LOG2;

`ifdef FB_PAINT_XOR_EN
    typedef enum logic [1:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_WAIT} state_t;
`else
    typedef enum logic {S_IDLE, S_WR_REQ} state_t;
    // Plain painting never reads the framebuffer.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_q [FIFO_DEPTH];
    logic [EW-1:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;

    logic            full, empty, in_range, push, pop;
    logic [EW-1:0]   head, push_entry;
    logic [31:0]     x_ext, y_ext;

    assign x_ext      = {24'd0, in_x};
    assign y_ext      = {24'd0, in_y};
    assign in_range   = (x_ext < 32'(DIM)) && (y_ext < 32'(DIM));
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push_entry = {in_y[FB_DIM_LOG2-1:0], in_x[FB_DIM_LOG2-1:0], px_data};
    assign head       = fifo_q[rd_ptr_q];
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign push       = paint && in_range && !full;
    assign pop        = (state_q == S_WR_REQ) && mem_grant;

    assign ready      = !full;
    assign idle       = empty && (state_q == S_IDLE);
    assign drop_cnt   = drop_cnt_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

    // Request FIFO bookkeeping and the saturating drop counter.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (paint && !push && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Access sequencer: request lines are registered so they hold steady while the arbiter withholds grant.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    mem_addr_d = head[EW-1:8];
`ifdef FB_PAINT_XOR_EN
                    mem_we_d   = 1'b0;
                    state_d    = S_RD_REQ;
`else
                    mem_we_d    = 1'b1;
                    mem_wdata_d = head[7:0];
                    state_d     = S_WR_REQ;
`endif
                end
            end
            S_WR_REQ: begin
                mem_req = 1'b1;
                if (mem_grant) state_d = S_IDLE;
            end
`ifdef FB_PAINT_XOR_EN
            S_RD_REQ: begin
                mem_req = 1'b1;
                if (mem_grant) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                mem_wdata_d = mem_rdata ^ head[7:0];
                mem_we_d    = 1'b1;
                state_d     = S_WR_REQ;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // All state resets asynchronously so an in-flight access is abandoned at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= 8'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_fb_paint_writer.sv
// Testbench for fb_paint_writer: drives paint strobes against a framebuffer RAM model with a scriptable grant.
// Expected writes come from a pixel-level model: accepted pixels in order, XOR against a shadow canvas when built so.
// Honours FB_PAINT_XOR_EN the same way as the design.
module tb_fb_paint_writer;
`ifdef FB_PAINT_XOR_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        paint;
    logic [7:0]  px_data, in_x, in_y;
    logic        ready, idle, mem_req, mem_we;
    logic [7:0]  drop_cnt, mem_wdata;
    logic        mem_grant = 1'b0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    fb_paint_writer #(.FIFO_DEPTH(4), .FB_DIM_LOG2(6)) dut (
        .clk(clk), .rst(rst), .paint(paint), .px_data(px_data), .in_x(in_x), .in_y(in_y),
        .ready(ready), .idle(idle), .drop_cnt(drop_cnt), .mem_req(mem_req), .mem_grant(mem_grant),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int errs = 0;

    // Grant driver: 0 = held low, 1 = held high, 2 = random, 3 = scripted pattern then low.
    int grant_mode = 0;
    int gpat_t0 = 0;
    int gpat_len = 0;
    bit gpat [16];
    always @(posedge clk) begin
        int idx;
        #2;
        idx = cyc - gpat_t0;
        case (grant_mode)
            0: mem_grant = 1'b0;
            1: mem_grant = 1'b1;
            2: mem_grant = 1'($urandom_range(0, 1));
            default: mem_grant = (idx >= 0 && idx < gpat_len) ? gpat[idx] : 1'b0;
        endcase
    end

    // Framebuffer RAM and access log, sampled mid-cycle.
    logic [7:0]  ram [4096];
    bit          ram_rdy = 1'b0;
    logic [11:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          wr_c [$];
    int          rd_n = 0, req_n = 0, rd_req_n = 0, unstable = 0;
    bit          prev_wait = 1'b0;
    logic [11:0] p_addr;
    logic        p_we;
    logic [7:0]  p_wdata;
    always @(negedge clk) begin
        if (!ram_rdy) begin
            for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
            ram_rdy = 1'b1;
        end
        if (mem_req === 1'b1) req_n++;
        if (mem_req === 1'b1 && mem_we === 1'b0) rd_req_n++;
        if (prev_wait && mem_req === 1'b1 &&
            (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata)) unstable++;
        prev_wait = (mem_req === 1'b1) && (mem_grant === 1'b0);
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        if (mem_req === 1'b1 && mem_grant === 1'b1) begin
            if (mem_we === 1'b1) begin
                wr_a.push_back(mem_addr); wr_d.push_back(mem_wdata); wr_c.push_back(cyc + 1);
                ram[mem_addr] = mem_wdata;
            end else begin
                rd_n++;
                mem_rdata = ram[mem_addr];
            end
        end
    end

    // Reference model state.
    logic [7:0]  mfb [4096];
    logic [11:0] exp_a [$];
    logic [7:0]  exp_d [$];
    int acc_n = 0, exp_drop = 0, last_cyc = 0;
    int wbase = 0, rbase = 0, qbase = 0, ubase = 0;

    function automatic logic [7:0] model_wdata(input logic [11:0] a, input logic [7:0] d);
`ifdef FB_PAINT_XOR_EN
        mfb[a] = mfb[a] ^ d;
`else
        mfb[a] = d;
`endif
        return mfb[a];
    endfunction

    task automatic clr();
        exp_a.delete(); exp_d.delete();
        wbase = wr_a.size(); rbase = rd_n; qbase = req_n; ubase = unstable;
    endtask

    // One paint strobe; returns the ready level the model expects and the one seen.
    task automatic send(input int x, input int y, input logic [7:0] d, output bit exp_rdy, output bit act_rdy);
        int occ;
        occ = acc_n - wr_a.size();
        exp_rdy = (occ < 4);
        act_rdy = ready;
        last_cyc = cyc;
        in_x = 8'(x); in_y = 8'(y); px_data = d; paint = 1'b1;
        if (x >= 64 || y >= 64 || occ >= 4) begin
            if (exp_drop < 255) exp_drop++;
        end else begin
            acc_n++;
            exp_a.push_back(12'((y << 6) | x));
            exp_d.push_back(d);
        end
        @(posedge clk); #1;
        paint = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (idle === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; paint = 1'b0; px_data = 8'h00; in_x = 8'h00; in_y = 8'h00;
        #3;
        vec++; if (ready !== 1'b1)      begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
        vec++; if (idle !== 1'b1)       begin errs++; $display("FAIL reset_idle: got %b want 1", idle); end
        vec++; if (drop_cnt !== 8'h00)  begin errs++; $display("FAIL reset_drop: got %h want 00", drop_cnt); end
        vec++; if (mem_req !== 1'b0)    begin errs++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vec++; if (mem_we !== 1'b0)     begin errs++; $display("FAIL reset_we: got %b want 0", mem_we); end
        vec++; if (mem_addr !== 12'h0)  begin errs++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        vec++; if (mem_wdata !== 8'h00) begin errs++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit r, a, ok;
        logic [7:0] ed;
        clr(); grant_mode = 1;
        @(posedge clk); #1;
        send(10, 20, 8'h1F, r, a);
        wait_idle(40, ok);
        vec++; if (!ok) begin errs++; $display("FAIL single_idle: idle never returned to 1"); end
        vec++;
        if (wr_a.size() - wbase !== 1) begin
            errs++; $display("FAIL single_count: got %0d writes want 1", wr_a.size() - wbase);
        end else begin
            ed = model_wdata(12'h50A, 8'h1F);
            vec++; if (wr_a[wbase] !== 12'h50A) begin errs++; $display("FAIL single_addr: got %h want 50A", wr_a[wbase]); end
            vec++; if (wr_d[wbase] !== ed) begin errs++; $display("FAIL single_data: got %h want %h", wr_d[wbase], ed); end
            vec++; if (wr_c[wbase] !== last_cyc + LAT) begin
                errs++; $display("FAIL single_latency: commit edge %0d want %0d", wr_c[wbase], last_cyc + LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        bit r, a, ok;
        int base;
        logic [7:0] ed;
        clr(); grant_mode = 0; base = exp_drop;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            send(i * 9 + 1, 60 - i * 5, 8'(8'h30 + i), r, a);
            vec++; if (a !== r) begin errs++; $display("FAIL bp_ready_%0d: got %b want %b", i, a, r); end
        end
        vec++; if (ready !== 1'b0) begin errs++; $display("FAIL bp_full: ready %b want 0", ready); end
        vec++; if (drop_cnt !== 8'(base + 2)) begin errs++; $display("FAIL bp_drop: got %0d want %0d", drop_cnt, base + 2); end
        grant_mode = 1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (wr_a.size() > wbase) begin ok = 1'b1; break; end
        end
        vec++; if (!ok) begin errs++; $display("FAIL bp_first_pop: no write within budget"); end
        vec++; if (ready !== 1'b0) begin errs++; $display("FAIL bp_ready_early: ready %b want 0 before pop edge", ready); end
        @(posedge clk); #1;
        vec++; if (ready !== 1'b1) begin errs++; $display("FAIL bp_ready_rise: ready %b want 1 after pop", ready); end
        wait_idle(60, ok);
        vec++; if (!ok) begin errs++; $display("FAIL bp_drain: idle never returned"); end
        vec++; if (wr_a.size() - wbase !== 4) begin errs++; $display("FAIL bp_count: got %0d want 4", wr_a.size() - wbase); end
        for (int i = 0; i < exp_a.size(); i++) begin
            ed = model_wdata(exp_a[i], exp_d[i]);
            if (wbase + i < wr_a.size()) begin
                vec++;
                if (wr_a[wbase + i] !== exp_a[i] || wr_d[wbase + i] !== ed) begin
                    errs++; $display("FAIL bp_write_%0d: got %h/%h want %h/%h", i, wr_a[wbase + i], wr_d[wbase + i], exp_a[i], ed);
                end
            end
        end
    endtask

    task automatic test_clip();
        bit r, a, ok;
        int base;
        clr(); grant_mode = 1; base = exp_drop;
        send(64, 5, 8'h11, r, a);
        send(3, 200, 8'h22, r, a);
        repeat (6) begin @(posedge clk); #1; end
        vec++; if (drop_cnt !== 8'(base + 2)) begin errs++; $display("FAIL clip_drop: got %0d want %0d", drop_cnt, base + 2); end
        vec++; if (req_n !== qbase) begin errs++; $display("FAIL clip_req: mem_req seen %0d cycles want 0", req_n - qbase); end
        wait_idle(1, ok);
        vec++; if (!ok) begin errs++; $display("FAIL clip_idle: idle %b want 1", idle); end
    endtask

    task automatic test_grant_stall();
        bit r, a, ok;
        logic [7:0] ed;
        clr(); grant_mode = 0;
        send(12, 34, 8'h5C, r, a);
        send(45, 6, 8'hC3, r, a);
        repeat (3) begin @(posedge clk); #1; end
        gpat[0] = 1'b0; gpat[1] = 1'b1; gpat[2] = 1'b0; gpat[3] = 1'b0; gpat[4] = 1'b1;
        gpat_len = 5; gpat_t0 = cyc; grant_mode = 3;
        repeat (8) begin @(posedge clk); #1; end
        grant_mode = 1;
        wait_idle(60, ok);
        vec++; if (!ok) begin errs++; $display("FAIL stall_drain: idle never returned"); end
        vec++; if (wr_a.size() - wbase !== 2) begin errs++; $display("FAIL stall_count: got %0d want 2", wr_a.size() - wbase); end
        vec++; if (unstable !== ubase) begin errs++; $display("FAIL stall_stable: %0d changes while waiting, want 0", unstable - ubase); end
        for (int i = 0; i < exp_a.size(); i++) begin
            ed = model_wdata(exp_a[i], exp_d[i]);
            if (wbase + i < wr_a.size()) begin
                vec++;
                if (wr_a[wbase + i] !== exp_a[i] || wr_d[wbase + i] !== ed) begin
                    errs++; $display("FAIL stall_write_%0d: got %h/%h want %h/%h", i, wr_a[wbase + i], wr_d[wbase + i], exp_a[i], ed);
                end
            end
        end
    endtask

`ifdef FB_PAINT_XOR_EN
    task automatic test_xor();
        bit r, a, ok;
        logic [7:0] ed;
        logic [7:0] want [3];
        logic [7:0] px [3];
        px[0] = 8'hAA; px[1] = 8'h0F; px[2] = 8'h0F;
        want[0] = 8'hAA; want[1] = 8'hA5; want[2] = 8'hAA;
        grant_mode = 1;
        for (int k = 0; k < 3; k++) begin
            clr();
            send(63, 63, px[k], r, a);
            wait_idle(40, ok);
            ed = model_wdata(12'hFFF, px[k]);
            vec++; if (!ok) begin errs++; $display("FAIL xor_idle_%0d: idle never returned", k); end
            vec++; if (rd_n - rbase !== 1) begin errs++; $display("FAIL xor_reads_%0d: got %0d reads want 1", k, rd_n - rbase); end
            vec++;
            if (wr_a.size() - wbase !== 1 || wr_d[wbase] !== want[k] || ed !== want[k]) begin
                errs++; $display("FAIL xor_wdata_%0d: got %0d writes, data %h want %h", k, wr_a.size() - wbase,
                                 (wr_a.size() > wbase) ? wr_d[wbase] : 8'h00, want[k]);
            end
        end
    endtask
`else
    task automatic test_plain_we();
        vec++; if (rd_req_n !== 0) begin errs++; $display("FAIL plain_we: %0d request cycles with mem_we=0, want 0", rd_req_n); end
        vec++; if (rd_n !== 0) begin errs++; $display("FAIL plain_reads: %0d granted reads, want 0", rd_n); end
    endtask
`endif

    task automatic test_random();
        bit r, a, ok;
        logic [7:0] ed;
        clr(); grant_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 71), $urandom_range(0, 71), 8'($urandom), r, a);
            vec++; if (a !== r) begin errs++; $display("FAIL rand_ready_%0d: got %b want %b", i, a, r); end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        wait_idle(2000, ok);
        vec++; if (!ok) begin errs++; $display("FAIL rand_drain: idle never returned"); end
        vec++; if (wr_a.size() - wbase !== exp_a.size()) begin
            errs++; $display("FAIL rand_count: got %0d writes want %0d", wr_a.size() - wbase, exp_a.size());
        end
        vec++; if (drop_cnt !== 8'(exp_drop)) begin errs++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, exp_drop); end
        vec++; if (unstable !== ubase) begin errs++; $display("FAIL rand_stable: %0d changes while waiting, want 0", unstable - ubase); end
        for (int i = 0; i < exp_a.size(); i++) begin
            ed = model_wdata(exp_a[i], exp_d[i]);
            if (wbase + i < wr_a.size()) begin
                vec++;
                if (wr_a[wbase + i] !== exp_a[i] || wr_d[wbase + i] !== ed) begin
                    errs++; $display("FAIL rand_write_%0d: got %h/%h want %h/%h", i, wr_a[wbase + i], wr_d[wbase + i], exp_a[i], ed);
                end
            end
        end
    endtask

    task automatic test_saturate();
        bit r, a, ok;
        logic [7:0] ed;
        clr(); grant_mode = 0;
        for (int i = 0; i < 4; i++) send(20 + i, 40, 8'(8'h70 + i), r, a);
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) send(200, i % 64, 8'h01, r, a);
            else send(i % 64, 9, 8'h02, r, a);
        end
        vec++; if (drop_cnt !== 8'(exp_drop)) begin errs++; $display("FAIL sat_drop: got %0d want %0d", drop_cnt, exp_drop); end
        vec++; if (drop_cnt !== 8'hFF) begin errs++; $display("FAIL sat_limit: got %0d want 255", drop_cnt); end
        grant_mode = 1;
        wait_idle(60, ok);
        vec++; if (!ok) begin errs++; $display("FAIL sat_drain: idle never returned"); end
        for (int i = 0; i < exp_a.size(); i++) begin
            ed = model_wdata(exp_a[i], exp_d[i]);
            vec++;
            if (wbase + i >= wr_a.size() || wr_a[wbase + i] !== exp_a[i] || wr_d[wbase + i] !== ed) begin
                errs++; $display("FAIL sat_write_%0d: missing or wrong write, want %h/%h", i, exp_a[i], ed);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit r, a, ok;
        int n0;
        clr(); grant_mode = 0;
        for (int i = 0; i < 3; i++) send(5 + i, 7, 8'(8'h60 + i), r, a);
`ifdef FB_PAINT_XOR_EN
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin @(posedge clk); #1; end
        gpat[0] = 1'b1; gpat_len = 1; gpat_t0 = cyc; grant_mode = 3;
`endif
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mem_req === 1'b1 && mem_we === 1'b1) begin ok = 1'b1; break; end
        end
        vec++; if (!ok) begin errs++; $display("FAIL rstmid_wrreq: write request never seen"); end
        n0 = wr_a.size();
        rst = 1'b1;
        #1;
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rstmid_req_async: mem_req %b want 0", mem_req); end
        @(posedge clk); #1;
        rst = 1'b0;
        acc_n = wr_a.size(); exp_a.delete(); exp_d.delete(); exp_drop = 0;
        grant_mode = 1;
        repeat (10) begin @(posedge clk); #1; end
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL rstmid_idle: got %b want 1", idle); end
        vec++; if (ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", ready); end
        vec++; if (drop_cnt !== 8'h00) begin errs++; $display("FAIL rstmid_drop: got %0d want 0", drop_cnt); end
        vec++; if (wr_a.size() !== n0) begin errs++; $display("FAIL rstmid_writes: %0d writes after reset want 0", wr_a.size() - n0); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mfb[i] = 8'h00;
        test_reset();
        test_single();
        test_backpressure();
        test_clip();
        test_grant_stall();
`ifdef FB_PAINT_XOR_EN
        test_xor();
`else
        test_plain_we();
`endif
        test_random();
        test_saturate();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errs %0d", errs);
        $fatal(1);
    end
endmodule
